sdg_keystream_packer: RTL and testbench

Downstream consumer of the self-decimated generator's serial keystream bit. Synchronises the bit into the system clock domain and decimates it to a fixed sample rate. Packs the samples MSB-first into WIDTH-bit words and presents them on a valid/ready interface. Flags dropped words and, optionally, a stuck generator.

---
 rtl/sdg_pkg.sv | 13 +
 rtl/sdg_sync2.sv | 21 ++
 rtl/sdg_keystream_packer.sv | 139 +++++++++++++
 tb/tb_sdg_keystream_packer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdg_pkg.sv
// rtl/sdg_pkg.sv - shared types and default sizes for the SDG keystream packer
package sdg_pkg;

  localparam int SDG_WIDTH_DEF   = 8;
  localparam int SDG_DECIM_DEF   = 4;
  localparam int SDG_RUN_MAX_DEF = 32;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/sdg_sync2.sv
// rtl/sdg_sync2.sv - two-flop synchroniser, async active-high reset to 0
module sdg_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdg_keystream_packer.sv
// rtl/sdg_keystream_packer.sv - decimate, pack and present SDG keystream words
// Optional repetition health test compiled in with SDG_HEALTH_EN.
module sdg_keystream_packer
  import sdg_pkg::*;
#(
  parameter int WIDTH   = SDG_WIDTH_DEF,
  parameter int DECIM   = SDG_DECIM_DEF,
  parameter int RUN_MAX = SDG_RUN_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  input  logic             word_rdy,
  output logic [WIDTH-1:0] word_out,
  output logic             word_vld,
  output logic             ovf,
  output logic             stuck
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DECIM - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || DECIM < 1 || RUN_MAX < 2) begin : g_param_check
    $error("sdg_keystream_packer: WIDTH>=2, DECIM>=1, RUN_MAX>=2 required");
  end

  logic             bit_s;
  logic [DW-1:0]    div;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] sh;
  logic             tick;
  logic             done;
  logic             discard;
  logic             load;
  logic [WIDTH-1:0] word_new;

  sdg_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bit_in),
    .q   (bit_s)
  );

  assign tick     = en && (div == DIV_LAST);
  assign done     = tick && (cnt == CNT_LAST);
  // Only WIDTH-1 history bits are kept; the completing sample joins on the fly.
  assign word_new = {sh, bit_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      cnt <= '0;
      sh  <= '0;
    end else begin
      if (en) div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        sh  <= word_new[WIDTH-2:0];
        cnt <= done ? '0 : cnt + 1'b1;
      end
    end
  end

`ifdef SDG_HEALTH_EN
  localparam int RW = $clog2(RUN_MAX + 1);
  localparam logic [RW-1:0] RC_MAX = RW'(RUN_MAX);

  logic [RW-1:0] rc;
  logic [RW-1:0] rc_next;
  logic          prev;

  // rc==0 only before the first sample, so it doubles as "no previous sample".
  always_comb begin
    rc_next = rc;
    if (rc == '0 || bit_s != prev) rc_next = RW'(1);
    else if (rc != RC_MAX)         rc_next = rc + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc    <= '0;
      prev  <= 1'b0;
      stuck <= 1'b0;
    end else if (tick) begin
      rc   <= rc_next;
      prev <= bit_s;
      if (rc_next == RC_MAX) stuck <= 1'b1;
    end
  end

  assign discard = stuck;
`else
  assign stuck   = 1'b0;
  assign discard = 1'b0;
`endif

  assign load = done && !discard;

  slot_state_t      slot;
  slot_state_t      slot_next;
  logic [WIDTH-1:0] word_next;
  logic             ovf_next;

  always_comb begin
    slot_next = slot;
    word_next = word_out;
    ovf_next  = ovf;
    case (slot)
      SLOT_EMPTY: begin
        if (load) begin
          slot_next = SLOT_FULL;
          word_next = word_new;
        end
      end
      SLOT_FULL: begin
        if (load && word_rdy) word_next = word_new;
        else if (load)        ovf_next  = 1'b1;
        else if (word_rdy)    slot_next = SLOT_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot     <= SLOT_EMPTY;
      word_out <= '0;
      ovf      <= 1'b0;
    end else begin
      slot     <= slot_next;
      word_out <= word_next;
      ovf      <= ovf_next;
    end
  end

  assign word_vld = (slot == SLOT_FULL);

endmodule

// File: tb/tb_sdg_keystream_packer.sv
// tb/tb_sdg_keystream_packer.sv - scoreboard bench for sdg_keystream_packer
module tb_sdg_keystream_packer;

  localparam int WIDTH   = 8;
  localparam int DECIM   = 4;
  localparam int RUN_MAX = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             bit_in = 1'b0;
  logic             word_rdy = 1'b0;
  logic [WIDTH-1:0] word_out;
  logic             word_vld;
  logic             ovf;
  logic             stuck;

  sdg_keystream_packer #(.WIDTH(WIDTH), .DECIM(DECIM), .RUN_MAX(RUN_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bit_in   (bit_in),
    .word_rdy (word_rdy),
    .word_out (word_out),
    .word_vld (word_vld),
    .ovf      (ovf),
    .stuck    (stuck)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_popped = 0;
  logic [WIDTH-1:0] last_out = '0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples are bit_in two edges late, one every DECIM enabled edges.
  bit   h1, h2, s, acc, tk, cpl, stuck_before, m_full, m_ovf, m_stuck, prev_s;
  int   ecnt, nbits, part, run;
  logic [WIDTH-1:0] w;

  always @(posedge clk) begin
    if (rst) begin
      h1 = 0; h2 = 0; ecnt = 0; nbits = 0; part = 0; run = 0; prev_s = 0;
      m_full = 0; m_ovf = 0; m_stuck = 0;
      exp_q.delete();
    end else begin
      s  = h2;
      h2 = h1;
      h1 = bit_in;
      acc = m_full && word_rdy;
      stuck_before = m_stuck;
      tk = 0;
      cpl = 0;
      if (en) begin
        ecnt = ecnt + 1;
        if (ecnt == DECIM) begin
          tk = 1;
          ecnt = 0;
        end
      end
      if (tk) begin
        part  = part * 2 + int'(s);
        nbits = nbits + 1;
        if (nbits == WIDTH) begin
          cpl = 1;
          w = WIDTH'(part);
          part = 0;
          nbits = 0;
        end
`ifdef SDG_HEALTH_EN
        if (run == 0 || s != prev_s) run = 1;
        else if (run < RUN_MAX) run = run + 1;
        prev_s = s;
        if (run == RUN_MAX) m_stuck = 1;
`endif
      end
      if (cpl && !stuck_before) begin
        if (!m_full || acc) begin
          m_full = 1;
          exp_q.push_back(w);
        end else begin
          m_ovf = 1;
        end
      end else if (acc) begin
        m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("word_vld", 32'(word_vld), 32'(m_full));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("stuck", 32'(stuck), 32'(m_stuck));
      if (word_vld) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", word_out, $time);
        end else begin
          check("word_out", 32'(word_out), 32'(exp_q[0]));
          if (word_rdy) begin
            last_out = word_out;
            void'(exp_q.pop_front());
            n_popped++;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in = v[i];
      cyc(DECIM);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    word_rdy = 1'b0;
    bit_in = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_word_out"}, 32'(word_out), 32'h0);
    check({tag, "_word_vld"}, 32'(word_vld), 32'h0);
    check({tag, "_ovf"}, 32'(ovf), 32'h0);
    check({tag, "_stuck"}, 32'(stuck), 32'h0);
  endtask

  int n0;

  initial begin
    cyc(3);
    check_zero_outputs("reset");

    // Single word, consumer always ready.
    rst = 1'b0;
    en = 1'b1;
    word_rdy = 1'b1;
    send_bits(8'hB2, 8);
    cyc(2);
    check("single_word", 32'(last_out), 32'hB2);
    check("single_ovf", 32'(ovf), 32'h0);

    // Consumer stalled across two completions.
    do_reset();
    en = 1'b1;
    send_bits(8'hB2, 8);
    send_bits(8'hB2, 8);
    cyc(1);
    check("stall_ovf", 32'(ovf), 32'h1);
    check("stall_vld", 32'(word_vld), 32'h1);
    check("stall_hold", 32'(word_out), 32'hB2);
    word_rdy = 1'b1;
    cyc(2);
    check("stall_delivered", 32'(last_out), 32'hB2);
    check("stall_vld_fall", 32'(word_vld), 32'h0);

    // Accept on the same edge as the next completion.
    do_reset();
    en = 1'b1;
    send_bits(8'h96, 8);
    send_bits(8'h34, 7);
    bit_in = 1'b1;
    cyc(DECIM - 1);
    word_rdy = 1'b1;
    cyc(1);
    word_rdy = 1'b0;
    check("nobubble_prev", 32'(last_out), 32'h96);
    check("nobubble_vld", 32'(word_vld), 32'h1);
    check("nobubble_word", 32'(word_out), 32'h69);
    check("nobubble_ovf", 32'(ovf), 32'h0);
    word_rdy = 1'b1;
    cyc(2);

    // Enable pause mid-word.
    do_reset();
    en = 1'b1;
    word_rdy = 1'b1;
    send_bits(8'h02, 3);
    en = 1'b0;
    cyc(20);
    en = 1'b1;
    send_bits(8'h1A, 5);
    cyc(2);
    check("pause_word", 32'(last_out), 32'h5A);
    check("pause_ovf", 32'(ovf), 32'h0);

    // Constant source for 40 samples.
    do_reset();
    en = 1'b1;
    word_rdy = 1'b1;
    n0 = n_popped;
    bit_in = 1'b1;
    cyc(40 * DECIM);
    cyc(2);
`ifdef SDG_HEALTH_EN
    check("stuck_set", 32'(stuck), 32'h1);
    check("stuck_words", 32'(n_popped - n0), 32'd4);
`else
    check("stuck_clear", 32'(stuck), 32'h0);
    check("stuck_words", 32'(n_popped - n0), 32'd5);
`endif
    check("stuck_last", 32'(last_out), 32'hFF);

    // Reset with the slot full and a partial word packed.
    do_reset();
    en = 1'b1;
    send_bits(8'hC3, 8);
    send_bits(8'h15, 5);
    rst = 1'b1;
    #1;
    check_zero_outputs("midreset");
    cyc(2);
    rst = 1'b0;
    en = 1'b1;
    word_rdy = 1'b1;
    n0 = n_popped;
    send_bits(8'h3C, 8);
    cyc(2);
    check("midreset_word", 32'(last_out), 32'h3C);
    check("midreset_count", 32'(n_popped - n0), 32'd1);

    // Randomised traffic: random bit holds, enable gaps and consumer stalls.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit_in = 1'($urandom);
      en = ($urandom_range(0, 9) != 0);
      for (int j = 0; j < int'($urandom_range(1, 8)); j++) begin
        word_rdy = ($urandom_range(0, 3) != 0);
        cyc(1);
      end
    end
    en = 1'b0;
    word_rdy = 1'b1;
    cyc(4);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_vld", 32'(word_vld), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
